// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// single-line memory port. Loads that hit return data combinationally.
module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [1:0]           dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - IDX_W - 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [2:0]           req_word;
  logic [LINE_BITS-1:0] line_rd;
  logic [31:0]          word_rd;
  logic                 hit;
  logic                 victim_dirty;
  logic                 store_hit;
  logic                 fill;
  logic                 unused_addr;

  assign req_tag      = cpu_addr_i[31:32-TAG_W];
  assign req_idx      = cpu_addr_i[5 +: IDX_W];
  assign req_word     = cpu_addr_i[4:2];
  assign unused_addr  = ^cpu_addr_i[1:0];

  assign line_rd      = data_q[req_idx];
  assign word_rd      = line_rd[req_word*32 +: 32];
  assign hit          = cpu_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];
  assign store_hit    = (state_q == IDLE) & hit & cpu_we_i;
  assign fill         = (state_q == REFILL) & mem_ack_i;

  // Only valid/dirty need clearing; stale tags/data are masked by valid=0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[req_idx] <= mem_data_i;
      tag_q[req_idx]  <= req_tag;
    end else if (store_hit) begin
      data_q[req_idx][req_word*32 +: 32] <= cpu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (cpu_req_i && !hit) state_d = victim_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ack_i) state_d = REFILL;
      REFILL:    if (mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, independent of the clock.
  always_comb begin
    cpu_rdata_o  = '0;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (rst_i) begin
      cpu_rdata_o = hit ? word_rd : 32'h0;
      case (state_q)
        IDLE: cpu_stall_o = cpu_req_i & ~hit;
        WRITEBACK: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {tag_q[req_idx], req_idx, 5'b0};
          mem_data_o   = line_rd;
        end
        REFILL: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {req_tag, req_idx, 5'b0};
        end
        default: ;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a per-cycle vector table covering fills,
// hits, writeback and store-allocate, plus a hand sequence for mid-refill reset.
module tb_dcache_ctrl;

  logic         clk;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [1:0]   dbg_state_o;

  dcache_ctrl #(.NUM_LINES(32), .LINE_BITS(256)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         ack;
    logic [255:0] mdi;
    logic         exp_stall;
    logic         exp_en;
    logic         exp_wr;
    logic [31:0]  exp_maddr;
    logic [31:0]  exp_rdata;
    logic [255:0] exp_mdo;
    logic [1:0]   exp_state;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int n_pass;
  int n_total;

  logic [255:0] la, lb, lc, ld, la_dirty, lc_dirty;

  function automatic logic [255:0] line_of(input logic [3:0] k);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = {k, 28'h0} | 32'(w);
    return l;
  endfunction

  function automatic vec_t mk(
    input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
    input logic ack, input logic [255:0] mdi,
    input logic st, input logic en, input logic wr, input logic [31:0] maddr,
    input logic [31:0] rdata, input logic [255:0] mdo, input logic [1:0] state);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.ack = ack; v.mdi = mdi;
    v.exp_stall = st; v.exp_en = en; v.exp_wr = wr; v.exp_maddr = maddr;
    v.exp_rdata = rdata; v.exp_mdo = mdo; v.exp_state = state;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_in(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ack, input logic [255:0] mdi);
    cpu_req_i = req; cpu_we_i = we; cpu_addr_i = addr;
    cpu_wdata_i = wdata; mem_ack_i = ack; mem_data_i = mdi;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    la = line_of(4'hA);
    lb = line_of(4'hB);
    lc = line_of(4'hC);
    ld = line_of(4'hD);
    la_dirty = la; la_dirty[31:0] = 32'hDEADBEEF;
    lc_dirty = lc; lc_dirty[95:64] = 32'h12345678;

    //            req we addr          wdata         ack mdi  stall en wr maddr         rdata         mdo       state
    vecs[0]  = mk(1, 0, 32'h0000_0404, 32'h0,        0, '0,  1, 0, 0, 32'h0,        32'h0,        '0,       2'd0);
    vecs[1]  = mk(1, 0, 32'h0000_0404, 32'h0,        0, '0,  1, 1, 0, 32'h0000_0400, 32'h0,       '0,       2'd2);
    vecs[2]  = mk(1, 0, 32'h0000_0404, 32'h0,        0, '0,  1, 1, 0, 32'h0000_0400, 32'h0,       '0,       2'd2);
    vecs[3]  = mk(1, 0, 32'h0000_0404, 32'h0,        0, '0,  1, 1, 0, 32'h0000_0400, 32'h0,       '0,       2'd2);
    vecs[4]  = mk(1, 0, 32'h0000_0404, 32'h0,        1, la,  1, 1, 0, 32'h0000_0400, 32'h0,       '0,       2'd2);
    vecs[5]  = mk(1, 0, 32'h0000_0404, 32'h0,        0, '0,  0, 0, 0, 32'h0,        32'hA000_0001, '0,      2'd0);
    vecs[6]  = mk(1, 1, 32'h0000_0400, 32'hDEADBEEF, 0, '0,  0, 0, 0, 32'h0,        32'hA000_0000, '0,      2'd0);
    vecs[7]  = mk(1, 0, 32'h0000_0400, 32'h0,        0, '0,  0, 0, 0, 32'h0,        32'hDEADBEEF, '0,       2'd0);
    vecs[8]  = mk(1, 0, 32'h0000_0800, 32'h0,        0, '0,  1, 0, 0, 32'h0,        32'h0,        '0,       2'd0);
    vecs[9]  = mk(1, 0, 32'h0000_0800, 32'h0,        1, '0,  1, 1, 1, 32'h0000_0400, 32'h0,       la_dirty, 2'd1);
    vecs[10] = mk(1, 0, 32'h0000_0800, 32'h0,        1, lb,  1, 1, 0, 32'h0000_0800, 32'h0,       '0,       2'd2);
    vecs[11] = mk(1, 0, 32'h0000_0800, 32'h0,        0, '0,  0, 0, 0, 32'h0,        32'hB000_0000, '0,      2'd0);
    vecs[12] = mk(1, 1, 32'h0000_0C08, 32'h12345678, 0, '0,  1, 0, 0, 32'h0,        32'h0,        '0,       2'd0);
    vecs[13] = mk(1, 1, 32'h0000_0C08, 32'h12345678, 1, lc,  1, 1, 0, 32'h0000_0C00, 32'h0,       '0,       2'd2);
    vecs[14] = mk(1, 1, 32'h0000_0C08, 32'h12345678, 0, '0,  0, 0, 0, 32'h0,        32'hC000_0002, '0,      2'd0);
    vecs[15] = mk(1, 0, 32'h0000_0C08, 32'h0,        0, '0,  0, 0, 0, 32'h0,        32'h12345678, '0,       2'd0);
    vecs[16] = mk(1, 0, 32'h0000_0400, 32'h0,        0, '0,  1, 0, 0, 32'h0,        32'h0,        '0,       2'd0);
    vecs[17] = mk(1, 0, 32'h0000_0400, 32'h0,        1, '0,  1, 1, 1, 32'h0000_0C00, 32'h0,       lc_dirty, 2'd1);
    vecs[18] = mk(1, 0, 32'h0000_0400, 32'h0,        1, la,  1, 1, 0, 32'h0000_0400, 32'h0,       '0,       2'd2);
    vecs[19] = mk(1, 0, 32'h0000_0400, 32'h0,        0, '0,  0, 0, 0, 32'h0,        32'hA000_0000, '0,      2'd0);
    vecs[20] = mk(0, 0, 32'h0000_0400, 32'h0,        1, '0,  0, 0, 0, 32'h0,        32'h0,        '0,       2'd0);
    vecs[21] = mk(0, 0, 32'h0000_0404, 32'h0,        0, '0,  0, 0, 0, 32'h0,        32'h0,        '0,       2'd0);

    // Reset held with a live request: every output must be low.
    rst_i = 1'b0;
    set_in(1, 1, 32'h0000_0404, 32'hFFFF_FFFF, 1, '1);
    #2;
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_en", mem_enable_o, 0);
    chk("rst_wr", mem_write_o, 0);
    chk("rst_maddr", mem_addr_o, 0);
    chk("rst_mdo", mem_data_o, 0);
    chk("rst_rdata", cpu_rdata_o, 0);
    chk("rst_state", dbg_state_o, 0);
    set_in(0, 0, 32'h0, 32'h0, 0, '0);
    #10 rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1 set_in(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].mdi);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), cpu_stall_o, vecs[i].exp_stall);
      chk($sformatf("v%0d_en", i), mem_enable_o, vecs[i].exp_en);
      chk($sformatf("v%0d_wr", i), mem_write_o, vecs[i].exp_wr);
      chk($sformatf("v%0d_maddr", i), mem_addr_o, vecs[i].exp_maddr);
      chk($sformatf("v%0d_rdata", i), cpu_rdata_o, vecs[i].exp_rdata);
      chk($sformatf("v%0d_mdo", i), mem_data_o, vecs[i].exp_mdo);
      chk($sformatf("v%0d_state", i), dbg_state_o, vecs[i].exp_state);
    end

    // Reset pulsed mid-refill: transaction abandoned, line stays invalid.
    @(posedge clk);
    #1 set_in(1, 0, 32'h0000_0424, 32'h0, 0, '0);
    @(negedge clk);
    chk("mr_miss_stall", cpu_stall_o, 1);
    @(posedge clk);
    #1;
    chk("mr_refill_state", dbg_state_o, 2);
    chk("mr_refill_en", mem_enable_o, 1);
    chk("mr_refill_maddr", mem_addr_o, 32'h0000_0420);
    rst_i = 1'b0;
    #1;
    chk("mr_rst_en", mem_enable_o, 0);
    chk("mr_rst_stall", cpu_stall_o, 0);
    chk("mr_rst_state", dbg_state_o, 0);
    chk("mr_rst_maddr", mem_addr_o, 0);
    mem_ack_i = 1'b1;
    mem_data_i = ld;
    @(posedge clk);
    #1 mem_ack_i = 1'b0;
    mem_data_i = '0;
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("mr_rel_stall", cpu_stall_o, 1);
    chk("mr_rel_rdata", cpu_rdata_o, 0);
    chk("mr_rel_en", mem_enable_o, 0);
    @(posedge clk);
    #1;
    chk("mr_re_state", dbg_state_o, 2);
    chk("mr_re_maddr", mem_addr_o, 32'h0000_0420);
    mem_ack_i = 1'b1;
    mem_data_i = ld;
    @(posedge clk);
    #1 mem_ack_i = 1'b0;
    mem_data_i = '0;
    chk("mr_fill_stall", cpu_stall_o, 0);
    chk("mr_fill_rdata", cpu_rdata_o, 32'hD000_0001);
    cpu_addr_i = 32'h0000_0400;
    #1;
    chk("mr_idx0_cleared", cpu_stall_o, 1);
    cpu_req_i = 1'b0;
    #1;
    chk("mr_noreq_stall", cpu_stall_o, 0);
    chk("mr_noreq_en", mem_enable_o, 0);
    @(posedge clk);
    #1;
    chk("mr_noreq_state", dbg_state_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
